urv_mem_arbiter: RTL and testbench

//  Shares one single-port, variable-latency memory between the uRV core's instruction-fetch and data ports.

---
 rtl/urv_mem_arbiter_pkg.sv | 14 +
 rtl/urv_wait_timer.sv | 42 ++++
 rtl/urv_mem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_urv_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/urv_mem_arbiter_pkg.sv
// Shared types and constants for the uRV memory arbiter.
//   marb_state_t : arbiter FSM states (idle, fetch wait, data wait)
//   SEL_WORD     : byte enables used for instruction fetches
package urv_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_I_WAIT = 2'd1,
        ST_D_WAIT = 2'd2
    } marb_state_t;

    localparam logic [3:0] SEL_WORD = 4'hF;

endpackage

// File: rtl/urv_wait_timer.sv
// Bus wait timer: loadable down-counter with an expired flag.
//   clk_i, rst_n_i : clock, async active-low reset
//   i_load         : reload to g_timeout_cycles-1 (on entry to a wait state)
//   i_en           : count down while waiting
//   o_expired      : counter has reached zero; tied low when g_timeout_cycles == 0
module urv_wait_timer #(
    parameter int g_timeout_cycles = 1024
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);

    generate
        if (g_timeout_cycles == 0) begin : g_off
            logic w_unused;
            assign w_unused  = &{1'b0, clk_i, rst_n_i, i_load, i_en};
            assign o_expired = 1'b0;
        end else begin : g_on
            localparam int W = (g_timeout_cycles < 2) ? 1 : $clog2(g_timeout_cycles);
            // Loaded on the grant edge, so the count reaches zero in the
            // g_timeout_cycles-th cycle spent waiting.
            localparam logic [W-1:0] LOAD_VAL = W'(g_timeout_cycles - 1);

            logic [W-1:0] r_cnt;

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i)
                    r_cnt <= '0;
                else if (i_load)
                    r_cnt <= LOAD_VAL;
                else if (i_en && r_cnt != '0)
                    r_cnt <= r_cnt - W'(1);
            end

            assign o_expired = (r_cnt == '0);
        end
    endgenerate

endmodule

// File: rtl/urv_mem_arbiter.sv
// Shares one single-port, variable-latency memory between the uRV fetch and
// data ports. One transaction at a time over a req/ack handshake; data wins
// unless a fetch has been starved for g_fetch_starve_limit data grants.
// A one-word fetch line is valid by address compare, so stale fetches after
// a branch are simply never marked valid. A wait timer aborts hung cycles.
//   clk_i/rst_n_i         : clock, async active-low reset
//   cpu_im_*              : fetch address in, instruction word + valid out
//   cpu_dm_*              : load/store strobes, address, data, byte enables,
//                           load data and done pulses out
//   mem_*                 : registered memory request, read data/ack in
//   err_timeout_o         : one-cycle pulse on a timeout abort
module urv_mem_arbiter
    import urv_mem_arbiter_pkg::*;
#(
    parameter int g_fetch_starve_limit = 4,
    parameter int g_timeout_cycles     = 1024
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] cpu_im_addr_i,
    output logic [31:0] cpu_im_data_o,
    output logic        cpu_im_valid_o,
    input  logic [31:0] cpu_dm_addr_i,
    input  logic [31:0] cpu_dm_data_s_i,
    input  logic [3:0]  cpu_dm_data_select_i,
    input  logic        cpu_dm_load_i,
    input  logic        cpu_dm_store_i,
    output logic [31:0] cpu_dm_data_l_o,
    output logic        cpu_dm_load_done_o,
    output logic        cpu_dm_store_done_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic [3:0]  mem_sel_o,
    output logic        mem_we_o,
    output logic        mem_req_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ack_i,
    output logic        err_timeout_o
);

    localparam logic [3:0] LIMIT = 4'(g_fetch_starve_limit);

    marb_state_t r_state;
    logic        r_pend, r_pend_we;
    logic [31:0] r_pend_addr, r_pend_data;
    logic [3:0]  r_pend_sel;
    logic        r_line_valid;
    logic [31:0] r_line_addr, r_line_data;
    logic [3:0]  r_starve;
    logic [31:0] r_mem_addr, r_mem_data;
    logic [3:0]  r_mem_sel;
    logic        r_mem_we, r_mem_req;
    logic [31:0] r_dm_data_l;
    logic        r_load_done, r_store_done, r_err;

    logic        w_strobe, w_capture, w_hit, w_fetch_wanted, w_pend_any;
    logic        w_d_grant, w_i_grant, w_expired;
    logic [31:0] w_nxt_addr, w_nxt_data;
    logic [3:0]  w_nxt_sel;
    logic        w_nxt_we;

    assign w_strobe       = cpu_dm_load_i | cpu_dm_store_i;
    assign w_capture      = !r_pend && w_strobe;
    assign w_hit          = r_line_valid && (r_line_addr == cpu_im_addr_i);
    assign w_fetch_wanted = !w_hit;

    // A strobe being latched this cycle already counts as pending, so the
    // data grant goes out on the same edge that captures it. Otherwise a
    // wanted fetch would slip in between every back-to-back data access.
    assign w_pend_any = r_pend | w_strobe;
    assign w_nxt_addr = r_pend ? r_pend_addr : cpu_dm_addr_i;
    assign w_nxt_data = r_pend ? r_pend_data : cpu_dm_data_s_i;
    assign w_nxt_sel  = r_pend ? r_pend_sel  : cpu_dm_data_select_i;
    assign w_nxt_we   = r_pend ? r_pend_we   : cpu_dm_store_i;

    assign w_d_grant = (r_state == ST_IDLE) && w_pend_any &&
                       (!w_fetch_wanted || r_starve < LIMIT);
    assign w_i_grant = (r_state == ST_IDLE) && !w_d_grant && w_fetch_wanted;

    urv_wait_timer #(
        .g_timeout_cycles (g_timeout_cycles)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .i_load    (w_d_grant | w_i_grant),
        .i_en      (r_state != ST_IDLE),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= ST_IDLE;
            r_pend       <= 1'b0;
            r_pend_we    <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_data  <= '0;
            r_pend_sel   <= '0;
            r_line_valid <= 1'b0;
            r_line_addr  <= '0;
            r_line_data  <= '0;
            r_starve     <= '0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_mem_sel    <= '0;
            r_mem_we     <= 1'b0;
            r_mem_req    <= 1'b0;
            r_dm_data_l  <= '0;
            r_load_done  <= 1'b0;
            r_store_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_load_done  <= 1'b0;
            r_store_done <= 1'b0;
            r_err        <= 1'b0;

            if (w_capture) begin
                r_pend      <= 1'b1;
                r_pend_addr <= cpu_dm_addr_i;
                r_pend_data <= cpu_dm_data_s_i;
                r_pend_sel  <= cpu_dm_data_select_i;
                r_pend_we   <= cpu_dm_store_i;   // store wins over load
            end

            if (!w_fetch_wanted || w_i_grant)
                r_starve <= '0;
            else if (w_d_grant && r_starve < LIMIT)
                r_starve <= r_starve + 4'd1;

            case (r_state)
                ST_IDLE: begin
                    if (w_d_grant) begin
                        r_mem_addr <= w_nxt_addr;
                        r_mem_data <= w_nxt_data;
                        r_mem_sel  <= w_nxt_sel;
                        r_mem_we   <= w_nxt_we;
                        r_mem_req  <= 1'b1;
                        r_state    <= ST_D_WAIT;
                    end else if (w_i_grant) begin
                        // r_mem_addr doubles as the captured fetch address
                        r_mem_addr <= cpu_im_addr_i;
                        r_mem_data <= '0;
                        r_mem_sel  <= SEL_WORD;
                        r_mem_we   <= 1'b0;
                        r_mem_req  <= 1'b1;
                        r_state    <= ST_I_WAIT;
                    end
                end
                ST_I_WAIT: begin
                    if (mem_ack_i) begin
                        r_line_addr  <= r_mem_addr;
                        r_line_data  <= mem_data_i;
                        r_line_valid <= 1'b1;
                        r_mem_req    <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else if (w_expired) begin
                        // line untouched; the fetch is simply retried
                        r_mem_req <= 1'b0;
                        r_err     <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_D_WAIT: begin
                    if (mem_ack_i || w_expired) begin
                        r_mem_req <= 1'b0;
                        r_pend    <= 1'b0;
                        r_state   <= ST_IDLE;
                        if (!mem_ack_i)
                            r_err <= 1'b1;
                        // an aborted access still completes so the core unstalls
                        if (r_pend_we) begin
                            r_store_done <= 1'b1;
                        end else begin
                            r_load_done <= 1'b1;
                            r_dm_data_l <= mem_ack_i ? mem_data_i : 32'h0;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cpu_im_valid_o      = w_hit;
    assign cpu_im_data_o       = r_line_data;
    assign cpu_dm_data_l_o     = r_dm_data_l;
    assign cpu_dm_load_done_o  = r_load_done;
    assign cpu_dm_store_done_o = r_store_done;
    assign mem_addr_o          = r_mem_addr;
    assign mem_data_o          = r_mem_data;
    assign mem_sel_o           = r_mem_sel;
    assign mem_we_o            = r_mem_we;
    assign mem_req_o           = r_mem_req;
    assign err_timeout_o       = r_err;

endmodule

// File: tb/tb_urv_mem_arbiter.sv
// Self-checking bench for urv_mem_arbiter. Memory model returns addr + 0x1000_0000
// after a programmable number of wait cycles (0 = ack in the first req cycle).
module tb_urv_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b1;
    logic [31:0] cpu_im_addr_i = '0;
    logic [31:0] cpu_im_data_o;
    logic        cpu_im_valid_o;
    logic [31:0] cpu_dm_addr_i = '0;
    logic [31:0] cpu_dm_data_s_i = '0;
    logic [3:0]  cpu_dm_data_select_i = '0;
    logic        cpu_dm_load_i = 1'b0;
    logic        cpu_dm_store_i = 1'b0;
    logic [31:0] cpu_dm_data_l_o;
    logic        cpu_dm_load_done_o;
    logic        cpu_dm_store_done_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [3:0]  mem_sel_o;
    logic        mem_we_o;
    logic        mem_req_o;
    logic [31:0] mem_data_i;
    logic        mem_ack_i;
    logic        err_timeout_o;

    always #5 clk_i = ~clk_i;

    urv_mem_arbiter #(
        .g_fetch_starve_limit (4),
        .g_timeout_cycles     (8)
    ) dut (
        .clk_i                (clk_i),
        .rst_n_i              (rst_n_i),
        .cpu_im_addr_i        (cpu_im_addr_i),
        .cpu_im_data_o        (cpu_im_data_o),
        .cpu_im_valid_o       (cpu_im_valid_o),
        .cpu_dm_addr_i        (cpu_dm_addr_i),
        .cpu_dm_data_s_i      (cpu_dm_data_s_i),
        .cpu_dm_data_select_i (cpu_dm_data_select_i),
        .cpu_dm_load_i        (cpu_dm_load_i),
        .cpu_dm_store_i       (cpu_dm_store_i),
        .cpu_dm_data_l_o      (cpu_dm_data_l_o),
        .cpu_dm_load_done_o   (cpu_dm_load_done_o),
        .cpu_dm_store_done_o  (cpu_dm_store_done_o),
        .mem_addr_o           (mem_addr_o),
        .mem_data_o           (mem_data_o),
        .mem_sel_o            (mem_sel_o),
        .mem_we_o             (mem_we_o),
        .mem_req_o            (mem_req_o),
        .mem_data_i           (mem_data_i),
        .mem_ack_i            (mem_ack_i),
        .err_timeout_o        (err_timeout_o)
    );

    // memory model
    logic        m_en = 1'b1;
    logic        m_force_ack = 1'b0;
    int unsigned m_lat = 0;
    int unsigned m_wcnt = 0;

    assign mem_ack_i  = (m_en && mem_req_o && m_wcnt == m_lat) || m_force_ack;
    assign mem_data_i = mem_addr_o + 32'h1000_0000;

    always @(posedge clk_i) begin
        if (!mem_req_o || mem_ack_i) m_wcnt <= 0;
        else                         m_wcnt <= m_wcnt + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_req(input string nm, input logic lvl, input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk_i);
            if (mem_req_o == lvl) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s: mem_req_o never reached %0b within %0d cycles", nm, lvl, lim);
    endtask

    typedef struct packed {
        logic [1:0]  kind;      // 0 fetch, 1 load, 2 store
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic        exp_we;
        logic [3:0]  exp_sel;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [6:0] got_we;
        int gi, n_st, n_done, n_wide, n_hi, n_err, n_d;
        logic prev_req, prev_done;

        vecs[0] = '{2'd0, 32'h0000_0000, 32'h0,         4'h0, 1'b0, 4'hF, 32'h1000_0000};
        vecs[1] = '{2'd0, 32'h0000_0004, 32'h0,         4'h0, 1'b0, 4'hF, 32'h1000_0004};
        vecs[2] = '{2'd0, 32'h0000_0008, 32'h0,         4'h0, 1'b0, 4'hF, 32'h1000_0008};
        vecs[3] = '{2'd1, 32'h0000_4000, 32'h0,         4'h3, 1'b0, 4'h3, 32'h1000_4000};
        vecs[4] = '{2'd2, 32'h0000_4010, 32'hCAFE_F00D, 4'hC, 1'b1, 4'hC, 32'h0};
        vecs[5] = '{2'd1, 32'h0000_4020, 32'h0,         4'hF, 1'b0, 4'hF, 32'h1000_4020};
        vecs[6] = '{2'd0, 32'h0000_000C, 32'h0,         4'h0, 1'b0, 4'hF, 32'h1000_000C};

        // reset state
        #1 rst_n_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst mem_req", mem_req_o, 0);
        chk("rst mem_addr", mem_addr_o, 0);
        chk("rst mem_we", mem_we_o, 0);
        chk("rst mem_sel", mem_sel_o, 0);
        chk("rst im_valid", cpu_im_valid_o, 0);
        chk("rst dones", {cpu_dm_load_done_o, cpu_dm_store_done_o, err_timeout_o}, 0);
        chk("rst data_l", cpu_dm_data_l_o, 0);
        rst_n_i = 1'b1;

        // table: fetches 0/4/8 back to back, mixed loads/stores, then a fetch
        for (int i = 0; i < 7; i++) begin
            case (vecs[i].kind)
                2'd0: cpu_im_addr_i = vecs[i].addr;
                2'd1: begin
                    cpu_dm_addr_i = vecs[i].addr; cpu_dm_data_s_i = vecs[i].wdata;
                    cpu_dm_data_select_i = vecs[i].sel; cpu_dm_load_i = 1'b1;
                end
                default: begin
                    cpu_dm_addr_i = vecs[i].addr; cpu_dm_data_s_i = vecs[i].wdata;
                    cpu_dm_data_select_i = vecs[i].sel; cpu_dm_store_i = 1'b1;
                end
            endcase
            @(negedge clk_i);
            cpu_dm_load_i = 1'b0;
            cpu_dm_store_i = 1'b0;
            chk($sformatf("v%0d req", i), mem_req_o, 1);
            chk($sformatf("v%0d addr", i), mem_addr_o, vecs[i].addr);
            chk($sformatf("v%0d we", i), mem_we_o, vecs[i].exp_we);
            chk($sformatf("v%0d sel", i), mem_sel_o, vecs[i].exp_sel);
            chk($sformatf("v%0d no done", i), {cpu_dm_load_done_o, cpu_dm_store_done_o}, 0);
            if (vecs[i].kind == 2'd2) chk($sformatf("v%0d wdata", i), mem_data_o, vecs[i].wdata);
            if (vecs[i].kind == 2'd0) chk($sformatf("v%0d valid in flight", i), cpu_im_valid_o, 0);
            @(negedge clk_i);
            chk($sformatf("v%0d req drop", i), mem_req_o, 0);
            case (vecs[i].kind)
                2'd0: begin
                    chk($sformatf("v%0d im_valid", i), cpu_im_valid_o, 1);
                    chk($sformatf("v%0d im_data", i), cpu_im_data_o, vecs[i].exp_rdata);
                end
                2'd1: begin
                    chk($sformatf("v%0d load_done", i), cpu_dm_load_done_o, 1);
                    chk($sformatf("v%0d data_l", i), cpu_dm_data_l_o, vecs[i].exp_rdata);
                end
                default: chk($sformatf("v%0d store_done", i), cpu_dm_store_done_o, 1);
            endcase
        end

        // stale fetch: branch away while 0x100 is in flight
        m_lat = 3;
        cpu_im_addr_i = 32'h100;
        wait_req("t2 req", 1'b1, 10);
        chk("t2 addr0", mem_addr_o, 32'h100);
        cpu_im_addr_i = 32'h200;
        wait_req("t2 ack0", 1'b0, 12);
        chk("t2 stale not valid", cpu_im_valid_o, 0);
        @(negedge clk_i);
        chk("t2 refetch req", mem_req_o, 1);
        chk("t2 refetch addr", mem_addr_o, 32'h200);
        chk("t2 still invalid", cpu_im_valid_o, 0);
        wait_req("t2 ack1", 1'b0, 12);
        chk("t2 valid", cpu_im_valid_o, 1);
        chk("t2 data", cpu_im_data_o, 32'h1000_0200);

        // load beats a wanted fetch, fetch follows
        m_lat = 0;
        cpu_im_addr_i = 32'h300;
        cpu_dm_addr_i = 32'h4000; cpu_dm_data_s_i = '0; cpu_dm_data_select_i = 4'hF;
        cpu_dm_load_i = 1'b1;
        @(negedge clk_i);
        cpu_dm_load_i = 1'b0;
        chk("t3 d grant", {mem_req_o, mem_we_o}, 2'b10);
        chk("t3 d addr", mem_addr_o, 32'h4000);
        @(negedge clk_i);
        chk("t3 load_done", cpu_dm_load_done_o, 1);
        chk("t3 data_l", cpu_dm_data_l_o, 32'h1000_4000);
        @(negedge clk_i);
        chk("t3 fetch req", mem_req_o, 1);
        chk("t3 fetch addr", mem_addr_o, 32'h300);
        chk("t3 done pulse", cpu_dm_load_done_o, 0);
        @(negedge clk_i);
        chk("t3 fetch valid", cpu_im_valid_o, 1);

        // starvation guard: 6 stores with a wanted fetch -> S S S S F S S
        cpu_im_addr_i = 32'h500;
        got_we = '0; gi = 0; n_done = 0; n_wide = 0;
        prev_req = 1'b0; prev_done = 1'b0;
        cpu_dm_addr_i = 32'h6000; cpu_dm_data_s_i = 32'h5000_0000; cpu_dm_store_i = 1'b1;
        n_st = 1;
        for (int c = 0; c < 80 && n_done < 6; c++) begin
            @(negedge clk_i);
            cpu_dm_store_i = 1'b0;
            if (mem_req_o && !prev_req && gi < 7) begin
                got_we[gi] = mem_we_o;
                gi++;
            end
            prev_req = mem_req_o;
            if (cpu_dm_store_done_o) begin
                n_done++;
                if (prev_done) n_wide++;
                if (n_st < 6) begin
                    cpu_dm_addr_i = 32'h6000 + 32'(4 * n_st);
                    cpu_dm_data_s_i = 32'h5000_0000 + 32'(n_st);
                    cpu_dm_store_i = 1'b1;
                    n_st++;
                end
            end
            prev_done = cpu_dm_store_done_o;
        end
        chk("t4 grant order", {25'h0, got_we}, 32'b1101111);
        chk("t4 grants", gi, 7);
        chk("t4 stores done", n_done, 6);
        chk("t4 done width", n_wide, 0);
        chk("t4 fetch valid", cpu_im_valid_o, 1);

        // timeout on a load with no ack
        m_en = 1'b0;
        cpu_dm_addr_i = 32'h7000; cpu_dm_load_i = 1'b1;
        n_hi = 0; n_err = 0;
        @(negedge clk_i);
        cpu_dm_load_i = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (mem_req_o) n_hi++;
            if (err_timeout_o) begin
                n_err++;
                chk("t5 load_done at abort", cpu_dm_load_done_o, 1);
                chk("t5 data_l zero", cpu_dm_data_l_o, 0);
                chk("t5 req low at abort", mem_req_o, 0);
            end
            @(negedge clk_i);
        end
        chk("t5 req cycles", n_hi, 8);
        chk("t5 err pulses", n_err, 1);
        m_force_ack = 1'b1;
        @(negedge clk_i);
        m_force_ack = 1'b0;
        n_d = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            if (cpu_dm_load_done_o || cpu_dm_store_done_o || mem_req_o || err_timeout_o) n_d++;
        end
        chk("t5 late ack ignored", n_d, 0);
        chk("t5 data_l kept", cpu_dm_data_l_o, 0);

        // async reset mid data wait
        cpu_dm_addr_i = 32'h7100; cpu_dm_load_i = 1'b1;
        @(negedge clk_i);
        cpu_dm_load_i = 1'b0;
        chk("t6 req before reset", mem_req_o, 1);
        @(negedge clk_i);
        #2 rst_n_i = 1'b0;
        #1 chk("t6 async req drop", mem_req_o, 0);
        cpu_im_addr_i = 32'h900;
        m_en = 1'b1;
        n_d = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            if (cpu_dm_load_done_o || cpu_dm_store_done_o) n_d++;
        end
        chk("t6 no done", n_d, 0);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        chk("t6 first req", mem_req_o, 1);
        chk("t6 is fetch", {mem_we_o, mem_sel_o}, 5'b01111);
        chk("t6 fetch addr", mem_addr_o, 32'h900);
        @(negedge clk_i);
        chk("t6 fetch valid", cpu_im_valid_o, 1);
        chk("t6 fetch data", cpu_im_data_o, 32'h1000_0900);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
